regfile8_wb: RTL and testbench

REGFILE8_WB -- requirements
Module: regfile8_wb

---
 rtl/regfile8_wb.sv | 121 ++++++++++++
 tb/tb_regfile8_wb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile8_wb.sv
// Eight-entry register file with X7 hardwired to zero, a write-through bypass and a
// sequential clear sequencer that zeroes X0..X6 one per cycle.
module regfile8_wb #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       en,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [2:0]       ReadRegister1,
    input  logic [2:0]       ReadRegister2,
    input  logic             clr_req,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             busy,
    output logic             en_err,
    output logic [15:0]      wr_count
);

    typedef enum logic {StIdle, StClear} state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] regs_q [7];
    logic             en_err_q;
    logic [15:0]      wr_count_q;
    logic             en_multi;
    logic             en_onehot;
    logic             wr_valid;

    // x & (x - 1) clears the lowest set bit; anything left means two or more bits.
    assign en_multi  = |(en & (en - 8'd1));
    assign en_onehot = (en != 8'd0) && !en_multi;
    assign wr_valid  = (state_q == StIdle) && en_onehot && !en[7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    ptr_d   = 3'd0;
                end
            end
            StClear: begin
                ptr_d = ptr_q + 3'd1;
                if (ptr_q == 3'd6) begin
                    state_d = StIdle;
                    ptr_d   = 3'd0;
                end
            end
            default: begin
                state_d = StIdle;
                ptr_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == StClear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 7; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (state_q == StClear && ptr_q == 3'(i)) begin
                    regs_q[i] <= '0;
                end else if (wr_valid && en[i]) begin
                    regs_q[i] <= WriteData;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_err_q   <= 1'b0;
            wr_count_q <= 16'd0;
        end else begin
            if (en_multi) begin
                en_err_q <= 1'b1;
            end
            if (wr_valid && wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign en_err   = en_err_q;
    assign wr_count = wr_count_q;

    // Address 7 falls through the loop and reads zero.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        for (int i = 0; i < 7; i++) begin
            if (ReadRegister1 == 3'(i)) begin
                ReadData1 = (wr_valid && en[i]) ? WriteData : regs_q[i];
            end
            if (ReadRegister2 == 3'(i)) begin
                ReadData2 = (wr_valid && en[i]) ? WriteData : regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile8_wb.sv
// Directed and randomized checks of regfile8_wb against an array-based reference model.
module tb_regfile8_wb;

    logic        clk;
    logic        reset_n;
    logic [7:0]  en;
    logic [63:0] WriteData;
    logic [2:0]  ReadRegister1;
    logic [2:0]  ReadRegister2;
    logic        clr_req;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic        busy;
    logic        en_err;
    logic [15:0] wr_count;

    int vectors;
    int miscompares;

    // Reference model state
    logic [63:0] m_regs [8];
    int          m_clr_left;
    int          m_clr_idx;
    bit          m_err;
    int          m_cnt;

    regfile8_wb #(.WIDTH(64)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .clr_req       (clr_req),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .busy          (busy),
        .en_err        (en_err),
        .wr_count      (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit write_ok(input logic [7:0] e);
        return ($countones(e) == 1) && (e != 8'h80);
    endfunction

    function automatic logic [63:0] exp_read(input logic [2:0] a);
        if (a == 3'd7) return 64'd0;
        if (m_clr_left == 0 && write_ok(en) && en[a]) return WriteData;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 64'd0;
        m_clr_left = 0;
        m_clr_idx  = 0;
        m_err      = 1'b0;
        m_cnt      = 0;
    endtask

    task automatic model_edge();
        if ($countones(en) >= 2) m_err = 1'b1;
        if (m_clr_left > 0) begin
            m_regs[m_clr_idx] = 64'd0;
            m_clr_idx++;
            m_clr_left--;
        end else begin
            if (write_ok(en)) begin
                for (int i = 0; i < 7; i++) if (en[i]) m_regs[i] = WriteData;
                if (m_cnt < 65535) m_cnt++;
            end
            if (clr_req) begin
                m_clr_left = 7;
                m_clr_idx  = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, "/rd1"}, ReadData1, exp_read(ReadRegister1));
        chk({tag, "/rd2"}, ReadData2, exp_read(ReadRegister2));
        chk({tag, "/busy"}, {63'd0, busy}, {63'd0, m_clr_left > 0});
        chk({tag, "/en_err"}, {63'd0, en_err}, {63'd0, m_err});
        chk({tag, "/wr_count"}, {48'd0, wr_count}, 64'(m_cnt));
    endtask

    task automatic drive(input logic [7:0] e, input logic [63:0] d, input logic [2:0] a1,
                         input logic [2:0] a2, input logic c);
        en            = e;
        WriteData     = d;
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        clr_req       = c;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic check_all_regs(input string tag);
        for (int a = 0; a < 8; a += 2) begin
            drive(8'h00, 64'd0, 3'(a), 3'(a + 1), 1'b0);
            check_all(tag);
        end
    endtask

    initial begin
        int nbusy;
        int r;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        drive(8'h00, 64'd0, 3'd0, 3'd0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_all_regs("reset");
        reset_n = 1'b1;

        // Basic write then read
        drive(8'h02, 64'hA5, 3'd0, 3'd0, 1'b0);
        tick();
        drive(8'h00, 64'd0, 3'd1, 3'd7, 1'b0);
        check_all("wr_rd");
        chk("wr_rd/x1", ReadData1, 64'hA5);
        chk("wr_rd/count1", {48'd0, wr_count}, 64'd1);

        // Same-cycle bypass on both ports
        drive(8'h08, 64'h1234, 3'd3, 3'd3, 1'b0);
        check_all("bypass");
        chk("bypass/rd1_const", ReadData1, 64'h1234);
        tick();
        drive(8'h00, 64'd0, 3'd3, 3'd3, 1'b0);
        check_all("bypass_after");

        // Zero register, then multi-hot error
        drive(8'h80, '1, 3'd7, 3'd7, 1'b0);
        check_all("x7_wr");
        tick();
        check_all("x7_after");
        drive(8'h05, 64'hDEAD_BEEF, 3'd0, 3'd2, 1'b0);
        check_all("multi");
        tick();
        drive(8'h00, 64'd0, 3'd0, 3'd2, 1'b0);
        check_all("multi_after");
        chk("multi/err_set", {63'd0, en_err}, 64'd1);

        // Randomized traffic, including occasional clears
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: en = 8'h00;
                1: en = 8'h80;
                2: en = 8'($urandom) | 8'h03;
                default: en = 8'(1 << $urandom_range(0, 6));
            endcase
            WriteData     = {$urandom, $urandom};
            ReadRegister1 = 3'($urandom_range(0, 7));
            ReadRegister2 = 3'($urandom_range(0, 7));
            clr_req       = ($urandom_range(0, 24) == 0);
            check_all("rand");
            tick();
        end
        drive(8'h00, 64'd0, 3'd0, 3'd0, 1'b0);
        repeat (8) tick();

        // Full clear: load, pulse, count busy cycles
        for (int i = 0; i < 7; i++) begin
            drive(8'(1 << i), 64'h100 + 64'(i), 3'd0, 3'd0, 1'b0);
            tick();
        end
        drive(8'h00, 64'd0, 3'd0, 3'd6, 1'b1);
        tick();
        nbusy = 0;
        for (int k = 0; k < 20; k++) begin
            drive(8'h01, 64'hFFFF, 3'(k % 8), 3'd0, 1'b1);
            check_all("clear_run");
            if (!busy) break;
            nbusy++;
            tick();
        end
        chk("clear/busy_cycles", 64'(nbusy), 64'd7);
        check_all_regs("clear_done");

        // Reset mid-clear, off the clock edge
        for (int i = 0; i < 7; i++) begin
            drive(8'(1 << i), 64'h200 + 64'(i), 3'd0, 3'd0, 1'b0);
            tick();
        end
        drive(8'h00, 64'd0, 3'd5, 3'd6, 1'b1);
        tick();
        drive(8'h00, 64'd0, 3'd5, 3'd6, 1'b0);
        tick();
        tick();
        #1;
        reset_n = 1'b0;
        model_reset();
        check_all_regs("reset_mid");

        // Writes are held off during reset; first edge after release takes one
        drive(8'h02, 64'h77, 3'd0, 3'd0, 1'b0);
        @(posedge clk);
        #2;
        drive(8'h00, 64'd0, 3'd1, 3'd2, 1'b0);
        check_all("reset_hold");
        reset_n = 1'b1;
        drive(8'h02, 64'h77, 3'd0, 3'd0, 1'b0);
        tick();
        drive(8'h00, 64'd0, 3'd1, 3'd2, 1'b0);
        check_all("post_reset_wr");

        // Saturation of the write counter
        for (int n = 0; n < 65540; n++) begin
            en        = 8'(1 << $urandom_range(0, 6));
            WriteData = {$urandom, $urandom};
            tick();
        end
        drive(8'h00, 64'd0, 3'($urandom_range(0, 6)), 3'd7, 1'b0);
        check_all("saturate");
        chk("saturate/ffff", {48'd0, wr_count}, 64'hFFFF);
        drive(8'h10, 64'h55, 3'd4, 3'd4, 1'b0);
        tick();
        drive(8'h00, 64'd0, 3'd4, 3'd0, 1'b0);
        check_all("saturate_hold");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
